// File: rtl/sha256_msg_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : sha256_msg_sched_if
// Description : Handshake bundle for the SHA-256 message scheduler. It holds
//               the message-word input stream, the schedule-word output
//               stream and the busy status flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface sha256_msg_sched_if #(
    parameter int WORD_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_word;
    logic              w_valid;
    logic              w_ready;
    logic [WORD_W-1:0] w_word;
    logic [5:0]        w_index;
    logic              w_last;
    logic              busy;

    // Scheduler side of the bundle
    modport slave (
        input  in_valid, in_word, w_ready,
        output in_ready, w_valid, w_word, w_index, w_last, busy
    );

    // Producer and consumer side of the bundle
    modport master (
        output in_valid, in_word, w_ready,
        input  in_ready, w_valid, w_word, w_index, w_last, busy
    );
endinterface
`default_nettype wire

// File: rtl/sha256_msg_sched.sv
`default_nettype none
// ============================================================================
// Module      : sha256_msg_sched
// Description : SHA-256 message schedule producer. It loads 16 message words
//               into a sliding window and then emits W0..W63 one word per
//               output transfer. Each new word comes from the small-sigma
//               expansion of the current window.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_msg_sched #(
    parameter int WORD_W     = 32,   // must be 32; the sigma functions assume it
    parameter int NUM_ROUNDS = 64
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    sha256_msg_sched_if.slave  bus
);

    typedef enum logic [0:0] {
        S_LOAD = 1'b0,
        S_GEN  = 1'b1
    } state_t;

    localparam logic [5:0] LAST_T = 6'(NUM_ROUNDS - 1);

    state_t            state;
    state_t            state_nx;
    logic [3:0]        load_cnt;
    logic [5:0]        t;
    logic [WORD_W-1:0] win [16];
    logic [WORD_W-1:0] w_next;
    logic              in_xfer;
    logic              out_xfer;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    assign in_xfer  = (state == S_LOAD) && bus.in_valid;
    assign out_xfer = (state == S_GEN) && bus.w_ready;

    // W_{t+16} comes from the current window. It is also computed for the
    // last 16 rounds, where the word is shifted in but never emitted.
    assign w_next = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];

    assign bus.in_ready = (state == S_LOAD);
    assign bus.w_valid  = (state == S_GEN);
    assign bus.w_word   = win[0];
    assign bus.w_index  = t;
    assign bus.w_last   = (state == S_GEN) && (t == LAST_T);
    assign bus.busy     = (state == S_GEN) || (load_cnt != 4'd0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_LOAD;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: leave LOAD on the 16th word, leave GEN after the last round
    always_comb begin
        state_nx = state;
        case (state)
            S_LOAD: begin
                if (in_xfer && (load_cnt == 4'd15)) begin
                    state_nx = S_GEN;
                end
            end
            S_GEN: begin
                if (out_xfer && (t == LAST_T)) begin
                    state_nx = S_LOAD;
                end
            end
            default: state_nx = S_LOAD;
        endcase
    end

    // Window, load counter and round counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt <= 4'd0;
            t        <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
        end else if (state == S_LOAD) begin
            if (in_xfer) begin
                win[load_cnt] <= bus.in_word;
                load_cnt      <= (load_cnt == 4'd15) ? 4'd0 : load_cnt + 4'd1;
                t             <= 6'd0;
            end
        end else if (out_xfer) begin
            for (int i = 0; i < 15; i++) begin
                win[i] <= win[i+1];
            end
            win[15] <= w_next;
            t       <= (t == LAST_T) ? 6'd0 : t + 6'd1;
        end
    end

endmodule
`default_nettype wire

// File: doc/sha256_msg_sched.md
Name: sha256_msg_sched

Overview:
Message-schedule producer for the SHA-256 compression datapath.
- Accepts one 512-bit block as 16 big-endian 32-bit words over a valid/ready input stream.
- Emits the 64 schedule words W0..W63 over a valid/ready output stream, in order, to the round logic.
- Uses a 16-word sliding window and the SHA-256 small-sigma expansion.

Parameters:
- WORD_W, 32, word width. Fixed at 32; any other value is illegal.
- NUM_ROUNDS, 64, number of schedule words emitted per block.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_word is valid.
- in_ready  output  1  block accepts a word this cycle.
- in_word  input  32  message word; first accepted word is M0.
- w_valid  output  1  w_word is valid.
- w_ready  input  1  consumer accepts w_word this cycle.
- w_word  output  32  schedule word W_t.
- w_index  output  6  t of the current w_word, 0..63.
- w_last  output  1  high with w_valid when w_index==63.
- busy  output  1  high in GEN, or in LOAD with load count >0.

Behaviour:
- Reset (async assert, sync release) clears:
  - state=LOAD, load count=0, t=0.
  - window r[0..15]=0.
  - in_ready=1, w_valid=0, w_index=0, w_last=0, busy=0.
- Input transfer on in_valid&in_ready. Output transfer on w_valid&w_ready.
- State LOAD:
  - in_ready=1, w_valid=0.
  - Each input transfer writes in_word into r[count], then count++.
  - On the 16th transfer (count==15): go to GEN, t=0.
  - First output is visible the cycle after the 16th input transfer (1-cycle latency).
- State GEN:
  - in_ready=0, w_valid=1, w_word=r[0], w_index=t, w_last=(t==63).
  - On output transfer, shift left: r[i]<=r[i+1] for i=0..14, r[15]<=next, t++.
  - next = sigma1(r[14]) + r[9] + sigma0(r[1]) + r[0], all mod 2^32, computed combinationally from the current window. This gives W_{t+16}.
  - sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - next is still computed for t>=48 (word never emitted); no separate gating is required.
  - No transfer: all registers hold; w_word and w_index are stable while w_valid && !w_ready.
  - Transfer at t==63: next cycle state=LOAD, count=0, t=0, w_valid=0, in_ready=1. There is no back-to-back overlap: the new block's first word is accepted no earlier than the cycle after W63 is transferred.
- in_word and in_valid are ignored in GEN. w_ready is ignored in LOAD.
- Reset mid-LOAD or mid-GEN discards the partial block and returns to the reset state immediately. No words are emitted for the aborted block.
- Throughput:
  - One output word per cycle with w_ready held high.
  - A block takes 16 + 64 = 80 cycles minimum.

Test Plan:
1. Reset, then "abc" padded block: M0=0x61626380, M1..M14=0, M15=0x00000018, in_valid held high.
   - in_ready drops after the 16th word.
   - Next cycle w_valid=1, w_index=0, w_word=0x61626380.
   - W15=0x00000018, W16=0x61626380, W17=0x000F0000.
   - Exactly 64 transfers; w_last only at index 63.
2. Same block with w_ready toggled pseudo-randomly:
   - w_word and w_index stable while stalled.
   - Emitted sequence identical to scenario 1 (compare all 64 against a software model).
3. in_valid gaps during LOAD (e.g. valid on every 3rd cycle):
   - Only 16 accepted words are stored.
   - Output matches the model.
   - busy high from the first accepted word.
4. Two blocks back-to-back, second block all-ones 0xFFFFFFFF:
   - in_ready returns 1 the cycle after W63 of block 1.
   - Block 2 W0..W15=0xFFFFFFFF.
   - Block 2 W16 = sigma1(0xFFFFFFFF)+0xFFFFFFFF+sigma0(0xFFFFFFFF)+0xFFFFFFFF, mod 2^32, checked against the model.
5. Assert rst_n low at w_index=30 (mid-GEN) and again after 7 words in LOAD:
   - Outputs go to reset values asynchronously.
   - A following full block produces the correct W0..W63 with no residue.
6. Drive in_valid with garbage during GEN: no effect on the emitted sequence; in_ready stays 0.
